// File: rtl/maj7_tt_sweeper.sv
// Truth-table sweeper for a small combinational network under test.
// Issues every input vector in ascending order, captures the network output
// into a 2^N_IN-bit table and presents it with a valid/ready handshake.
// Optional feature macro: TT_ONES_EN adds o_ones_cnt (number of 1s in o_tt).
`timescale 1ns/1ps

module maj7_tt_sweeper #(
  parameter int unsigned N_IN     = 7,
  parameter int unsigned PIPE_LAT = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic [N_IN-1:0]        o_x_out,
  input  logic                   i_f_in,
  output logic [(1<<N_IN)-1:0]   o_tt,
  output logic                   o_tt_valid,
`ifdef TT_ONES_EN
  input  logic                   i_tt_ready,
  output logic [N_IN:0]          o_ones_cnt
`else
  input  logic                   i_tt_ready
`endif
);

  localparam int unsigned TtW  = 1 << N_IN;
  // Drain counter runs 0..PIPE_LAT-1; keep at least one bit when unused.
  localparam int unsigned DrnW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DrnW-1:0] DrnLast = (PIPE_LAT > 0) ? DrnW'(PIPE_LAT - 1) : '0;
  localparam logic [N_IN:0]   IdxLast = (N_IN + 1)'(TtW - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StHold} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [N_IN:0]     r_idx;
  logic [DrnW-1:0]   r_drn_cnt;
  logic [TtW-1:0]    r_tt;
  logic              w_accept;
  logic              w_last_issue;
  logic              w_flush;
  logic              w_cap_vld;
  logic [N_IN-1:0]   w_cap_idx;

  assign w_accept     = (r_state == StIdle) & i_start & ~i_abort;
  assign w_last_issue = (r_state == StSweep) & (r_idx == IdxLast);
  assign w_flush      = i_abort & ((r_state == StSweep) | (r_state == StDrain));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; abort only matters while a sweep is in flight
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StSweep;
      StSweep: begin
        if (i_abort)           w_state_nxt = StIdle;
        else if (w_last_issue) w_state_nxt = (PIPE_LAT > 0) ? StDrain : StHold;
      end
      StDrain: begin
        if (i_abort)                   w_state_nxt = StIdle;
        else if (r_drn_cnt == DrnLast) w_state_nxt = StHold;
      end
      StHold:  if (i_tt_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs decoded from state; x_out is only driven during the sweep
  always_comb begin
    o_busy     = (r_state == StSweep) | (r_state == StDrain);
    o_tt_valid = (r_state == StHold);
    o_x_out    = (r_state == StSweep) ? r_idx[N_IN-1:0] : '0;
  end

  // Vector index and drain counter; both restart from zero outside their state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_drn_cnt <= '0;
    end else begin
      if ((r_state == StSweep) && !i_abort && !w_last_issue) r_idx <= r_idx + 1'b1;
      else                                                   r_idx <= '0;
      if (r_state == StDrain) r_drn_cnt <= r_drn_cnt + 1'b1;
      else                    r_drn_cnt <= '0;
    end
  end

  if (PIPE_LAT == 0) begin : g_nopipe
    assign w_cap_vld = (r_state == StSweep);
    assign w_cap_idx = r_idx[N_IN-1:0];
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] r_tag_vld;
    logic [N_IN-1:0]     r_tag_idx [PIPE_LAT];

    // Tagged index delay line matching the network latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_tag_vld <= '0;
        for (int i = 0; i < int'(PIPE_LAT); i++) r_tag_idx[i] <= '0;
      end else if (w_flush) begin
        r_tag_vld <= '0;
      end else begin
        r_tag_vld[0] <= (r_state == StSweep);
        r_tag_idx[0] <= r_idx[N_IN-1:0];
        for (int i = 1; i < int'(PIPE_LAT); i++) begin
          r_tag_vld[i] <= r_tag_vld[i-1];
          r_tag_idx[i] <= r_tag_idx[i-1];
        end
      end
    end

    assign w_cap_vld = r_tag_vld[PIPE_LAT-1];
    assign w_cap_idx = r_tag_idx[PIPE_LAT-1];
  end

  // Truth table: cleared on start accept, one bit written per tagged sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_tt <= '0;
    else if (w_accept)  r_tt <= '0;
    else if (w_cap_vld) r_tt[w_cap_idx] <= i_f_in;
  end

  assign o_tt = r_tt;

`ifdef TT_ONES_EN
  logic [N_IN:0] r_ones_cnt;

  // Running population count of the captured bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ones_cnt <= '0;
    else if (w_accept)  r_ones_cnt <= '0;
    else if (w_cap_vld) r_ones_cnt <= r_ones_cnt + (N_IN + 1)'(i_f_in);
  end

  assign o_ones_cnt = r_ones_cnt;
`endif

endmodule

// File: tb/tb_maj7_tt_sweeper.sv
// Bench for maj7_tt_sweeper: two instances (PIPE_LAT 0 and 1) share stimulus and are
// checked every cycle against a cycle-count model of the sweep.
`timescale 1ns/1ps

module tb_maj7_tt_sweeper;

  localparam int unsigned NIn = 7;
  localparam int unsigned TtW = 128;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             tt_ready = 1'b0;
  logic [1:0]       busy_v;
  logic [1:0]       valid_v;
  logic [NIn-1:0]   x_v [2];
  logic [TtW-1:0]   tt_v [2];
`ifdef TT_ONES_EN
  logic [NIn:0]     ones_v [2];
`endif
  logic             f0;
  logic             f1 = 1'b0;
  logic [TtW-1:0]   g_tbl = '0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Model state per instance: phase 0 idle, 1 running (cycle k), 2 holding
  int             m_ph [2] = '{0, 0};
  int             m_k [2] = '{0, 0};
  bit             m_known [2] = '{1'b1, 1'b1};
  logic [TtW-1:0] m_tbl [2] = '{'0, '0};
  logic [TtW-1:0] m_idle_tt [2] = '{'0, '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maj7_tt_sweeper #(.N_IN(NIn), .PIPE_LAT(0)) u_dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .o_busy     (busy_v[0]),
    .o_x_out    (x_v[0]),
    .i_f_in     (f0),
    .o_tt       (tt_v[0]),
    .o_tt_valid (valid_v[0]),
`ifdef TT_ONES_EN
    .o_ones_cnt (ones_v[0]),
`endif
    .i_tt_ready (tt_ready)
  );

  maj7_tt_sweeper #(.N_IN(NIn), .PIPE_LAT(1)) u_dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .o_busy     (busy_v[1]),
    .o_x_out    (x_v[1]),
    .i_f_in     (f1),
    .o_tt       (tt_v[1]),
    .o_tt_valid (valid_v[1]),
`ifdef TT_ONES_EN
    .o_ones_cnt (ones_v[1]),
`endif
    .i_tt_ready (tt_ready)
  );

  // Network under test: combinational for instance 0, one register for instance 1
  assign f0 = g_tbl[x_v[0]];
  always @(posedge clk) f1 <= g_tbl[x_v[1]];

  task automatic chk(input string nm, input logic [TtW-1:0] act, input logic [TtW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TtW-1:0] make_tbl(input int sel, input logic [TtW-1:0] rnd);
    logic [TtW-1:0] t;
    for (int i = 0; i < int'(TtW); i++) begin
      int c = 0;
      for (int j = 0; j < 7; j++) c += (i >> j) & 1;
      case (sel)
        0:       t[i] = (i % 2) == 1;
        1:       t[i] = (((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2);
        2:       t[i] = 1'b1;
        3:       t[i] = rnd[i];
        default: t[i] = (c >= 4);
      endcase
    end
    return t;
  endfunction

  function automatic logic [TtW-1:0] part_tt(input logic [TtW-1:0] tbl, input int n);
    logic [TtW-1:0] one = 1;
    if (n <= 0) return '0;
    if (n >= int'(TtW)) return tbl;
    return tbl & ((one << n) - one);
  endfunction

  // Reference model: tracks how far each sweep has progressed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d]      <= 0;
        m_k[d]       <= 0;
        m_known[d]   <= 1'b1;
        m_idle_tt[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (m_ph[d])
          0: if (start && !abort) begin
            m_ph[d]  <= 1;
            m_k[d]   <= 1;
            m_tbl[d] <= g_tbl;
          end
          1: begin
            if (abort) begin
              m_ph[d]    <= 0;
              m_known[d] <= 1'b0;
            end else if (m_k[d] == 128 + d) begin
              m_ph[d] <= 2;
            end else begin
              m_k[d] <= m_k[d] + 1;
            end
          end
          default: if (tt_ready) begin
            m_ph[d]      <= 0;
            m_idle_tt[d] <= m_tbl[d];
            m_known[d]   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic [TtW-1:0] e_tt;
        bit             have_tt;
        int             x_exp;
        x_exp   = (m_ph[d] == 1 && m_k[d] <= 128) ? m_k[d] - 1 : 0;
        have_tt = 1'b1;
        if (m_ph[d] == 1)      e_tt = part_tt(m_tbl[d], m_k[d] - 1 - d);
        else if (m_ph[d] == 2) e_tt = m_tbl[d];
        else begin
          e_tt    = m_idle_tt[d];
          have_tt = m_known[d];
        end
        chk($sformatf("busy%0d", d), busy_v[d], m_ph[d] == 1);
        chk($sformatf("x_out%0d", d), x_v[d], x_exp);
        chk($sformatf("tt_valid%0d", d), valid_v[d], m_ph[d] == 2);
        if (have_tt) begin
          chk($sformatf("tt%0d", d), tt_v[d], e_tt);
`ifdef TT_ONES_EN
          chk($sformatf("ones%0d", d), ones_v[d], $countones(e_tt));
`endif
        end
      end
    end
  end

  task automatic run_sweep(input int sel, input logic [TtW-1:0] rnd, input int rdelay,
                           input bit lit_en, input logic [TtW-1:0] lit, input int lit_ones);
    int acc;
    int first0 = -1;
    int first1 = -1;
    int nbusy1 = 0;
    int iter = 0;
    g_tbl = make_tbl(sel, rnd);
    start = 1'b1;
    acc   = cyc;
    next_cyc();
    start = 1'b0;
    while (iter < 400) begin
      if (valid_v[0] && first0 < 0) first0 = cyc;
      if (valid_v[1] && first1 < 0) first1 = cyc;
      if (busy_v[1]) nbusy1++;
      if (first0 >= 0 && first1 >= 0) break;
      // Start and ready pulses mid-sweep must be ignored
      if (cyc - acc < 120) begin
        start    = ($urandom_range(0, 3) == 0);
        tt_ready = ($urandom_range(0, 3) == 0);
      end else begin
        start    = 1'b0;
        tt_ready = 1'b0;
      end
      next_cyc();
      iter++;
    end
    start    = 1'b0;
    tt_ready = 1'b0;
    if (iter >= 400) chk("sweep_timeout", 0, 1);
    chk("latency0", first0 - acc, 129);
    chk("latency1", first1 - acc, 130);
    chk("busy1_cycles", nbusy1, 129);
    // Hold with ready low; start and abort are ignored here
    for (int i = 0; i < rdelay; i++) begin
      start = ($urandom_range(0, 1) == 1);
      abort = ($urandom_range(0, 1) == 1);
      next_cyc();
    end
    start = 1'b0;
    abort = 1'b0;
    chk("hold_valid0", valid_v[0], 1);
    chk("hold_valid1", valid_v[1], 1);
    if (lit_en) begin
      chk("lit_tt0", tt_v[0], lit);
      chk("lit_tt1", tt_v[1], lit);
`ifdef TT_ONES_EN
      chk("lit_ones0", ones_v[0], lit_ones);
      chk("lit_ones1", ones_v[1], lit_ones);
`endif
    end
    tt_ready = 1'b1;
    next_cyc();
    tt_ready = 1'b0;
    chk("release_valid0", valid_v[0], 0);
    chk("release_valid1", valid_v[1], 0);
  endtask

  initial begin
    int acc;
    logic [TtW-1:0] rnd;
    repeat (3) next_cyc();
    chk("reset_tt0", tt_v[0], 0);
    chk("reset_tt1", tt_v[1], 0);
    chk("reset_busy", busy_v, 0);
    chk("reset_valid", valid_v, 0);
    rst_n = 1'b1;
    next_cyc();

    // Parity, 3-input majority, and constant one (long hold)
    run_sweep(0, '0, 2, 1'b1, {16{8'hAA}}, 64);
    run_sweep(1, '0, 3, 1'b1, {16{8'hE8}}, 64);
    run_sweep(2, '0, 20, 1'b1, {TtW{1'b1}}, 128);

    // Abort mid-sweep, then a normal sweep
    g_tbl = make_tbl(4, '0);
    start = 1'b1;
    acc   = cyc;
    next_cyc();
    start = 1'b0;
    while (cyc < acc + 50) next_cyc();
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    chk("abort_busy", busy_v, 0);
    chk("abort_x0", x_v[0], 0);
    chk("abort_x1", x_v[1], 0);
    repeat (5) next_cyc();
    chk("abort_valid", valid_v, 0);
    run_sweep(4, '0, 1, 1'b0, '0, 0);

    // Asynchronous reset mid-sweep
    rnd   = {$urandom, $urandom, $urandom, $urandom};
    g_tbl = make_tbl(3, rnd);
    start = 1'b1;
    acc   = cyc;
    next_cyc();
    start = 1'b0;
    while (cyc < acc + 70) next_cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy_v, 0);
    chk("rst_valid", valid_v, 0);
    chk("rst_x0", x_v[0], 0);
    chk("rst_x1", x_v[1], 0);
    chk("rst_tt0", tt_v[0], 0);
    chk("rst_tt1", tt_v[1], 0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    run_sweep(3, rnd, 2, 1'b0, '0, 0);

    // Start together with abort in idle: nothing starts
    start = 1'b1;
    abort = 1'b1;
    next_cyc();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_busy", busy_v, 0);
      next_cyc();
    end

    // Randomised sweeps
    for (int n = 0; n < 8; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_sweep(int'($urandom_range(0, 4)), rnd, int'($urandom_range(0, 5)), 1'b0, '0, 0);
      repeat ($urandom_range(0, 3)) next_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
